// File: rtl/stage_frame_scanner.sv
// -----------------------------------------------------------------------------
// stage_frame_scanner
//
// Walks a H_ACTIVE x V_ACTIVE raster and asks an external combinational
// renderer for each pixel. The result is captured in a valid/ready output
// register and handed to a framebuffer writer. The selected stage is latched
// at frame start and drives the external renderer mux for the whole frame.
//
// Ports
//   clk         single clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   start       frame request, level-sampled while idle
//   abort       synchronous frame cancel (ignored while idle)
//   stage_sel   stage to render, captured with an accepted start
//   stage_out   latched stage_sel, selects the external renderer
//   rend_x      current column presented to the renderer
//   rend_y      current row presented to the renderer
//   rend_color  renderer result {r[2:0],g[2:0],b[1:0]} for rend_x/rend_y
//   pix_valid   pix_addr/pix_data hold a pixel for the framebuffer
//   pix_ready   framebuffer accepts the held pixel this cycle
//   pix_addr    linear address y*H_ACTIVE+x
//   pix_data    captured rend_color
//   busy        frame in progress
//   done        one-cycle completion pulse
// -----------------------------------------------------------------------------
module stage_frame_scanner #(
  parameter int H_ACTIVE = 80,
  parameter int V_ACTIVE = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  stage_sel,
  output logic [2:0]  stage_out,
  output logic [6:0]  rend_x,
  output logic [6:0]  rend_y,
  input  logic [7:0]  rend_color,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [12:0] pix_addr,
  output logic [7:0]  pix_data,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0] X_LAST = 7'(H_ACTIVE - 1);
  localparam logic [6:0] Y_LAST = 7'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;

  logic [6:0]  x_r, x_nxt_s;
  logic [6:0]  y_r, y_nxt_s;
  logic [12:0] addr_r, addr_nxt_s;
  logic [2:0]  stage_r, stage_nxt_s;
  logic        valid_r, valid_nxt_s;
  logic [12:0] paddr_r, paddr_nxt_s;
  logic [7:0]  pdata_r, pdata_nxt_s;
  logic        busy_r;
  logic        done_r, done_nxt_s;

  logic        accept_s;
  logic        abort_s;
  logic        load_s;
  logic        last_s;

  // Qualifiers shared by the FSM and the datapath.
  always_comb begin
    accept_s = (state_r == IDLE) && start;
    abort_s  = (state_r != IDLE) && abort;
    // The output register takes a new pixel whenever it is empty or draining.
    load_s   = (state_r == SCAN) && (!valid_r || pix_ready);
    last_s   = (x_r == X_LAST) && (y_r == Y_LAST);
  end

  // Next-state logic; abort wins over every other transition.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (load_s && last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_nxt_s = IDLE;
        end else if (valid_r && pix_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Datapath next values: raster counters, output register, done pulse.
  always_comb begin
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    addr_nxt_s  = addr_r;
    stage_nxt_s = stage_r;
    valid_nxt_s = valid_r;
    paddr_nxt_s = paddr_r;
    pdata_nxt_s = pdata_r;
    done_nxt_s  = (state_r == DRAIN) && !abort && valid_r && pix_ready;

    if (accept_s) begin
      x_nxt_s     = 7'd0;
      y_nxt_s     = 7'd0;
      addr_nxt_s  = 13'd0;
      stage_nxt_s = stage_sel;
    end else if (abort_s) begin
      // Counters are left as-is; the next accepted start clears them.
      valid_nxt_s = 1'b0;
    end else if (load_s) begin
      valid_nxt_s = 1'b1;
      paddr_nxt_s = addr_r;
      pdata_nxt_s = rend_color;
      // The final pixel parks the counters so pix_addr never overruns.
      if (!last_s) begin
        addr_nxt_s = addr_r + 13'd1;
        if (x_r == X_LAST) begin
          x_nxt_s = 7'd0;
          y_nxt_s = y_r + 7'd1;
        end else begin
          x_nxt_s = x_r + 7'd1;
          y_nxt_s = y_r;
        end
      end else begin
        addr_nxt_s = addr_r;
      end
    end else if (pix_ready) begin
      valid_nxt_s = 1'b0;
    end else begin
      valid_nxt_s = valid_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath registers; busy is registered from the next state so it tracks state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r     <= 7'd0;
      y_r     <= 7'd0;
      addr_r  <= 13'd0;
      stage_r <= 3'd0;
      valid_r <= 1'b0;
      paddr_r <= 13'd0;
      pdata_r <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      addr_r  <= addr_nxt_s;
      stage_r <= stage_nxt_s;
      valid_r <= valid_nxt_s;
      paddr_r <= paddr_nxt_s;
      pdata_r <= pdata_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= done_nxt_s;
    end
  end

  assign stage_out = stage_r;
  assign rend_x    = x_r;
  assign rend_y    = y_r;
  assign pix_valid = valid_r;
  assign pix_addr  = paddr_r;
  assign pix_data  = pdata_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: doc/stage_frame_scanner.md
STAGE_FRAME_SCANNER -- requirements
Module: stage_frame_scanner

Interface
REQ-001 Parameter H_ACTIVE, default 80, pixels per line.
REQ-002 Parameter V_ACTIVE, default 60, lines per frame.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  frame render request, level-sampled in IDLE.
REQ-006 abort  input  1  synchronous frame cancel.
REQ-007 stage_sel  input  3  stage renderer to display, sampled with accepted start.
REQ-008 stage_out  output  3  latched stage_sel, drives external renderer mux.
REQ-009 rend_x  output  7  current column to renderer, 0..H_ACTIVE-1.
REQ-010 rend_y  output  7  current row to renderer, 0..V_ACTIVE-1.
REQ-011 rend_color  input  8  combinational renderer result {red[2:0],green[2:0],blue[1:0]} for rend_x/rend_y.
REQ-012 pix_valid  output  1  pix_addr/pix_data hold a pixel for the framebuffer.
REQ-013 pix_ready  input  1  framebuffer accepts pixel this cycle.
REQ-014 pix_addr  output  13  linear address y*H_ACTIVE+x.
REQ-015 pix_data  output  8  captured rend_color.
REQ-016 busy  output  1  frame in progress.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 FSM states SHALL be IDLE, SCAN, DRAIN.
REQ-019 IDLE: start=1 SHALL latch stage_sel into stage_out, clear x/y/address counters to 0, enter SCAN next cycle.
REQ-020 start outside IDLE SHALL be ignored; stage_sel changes outside IDLE SHALL not affect stage_out.
REQ-021 Output register SHALL load when in SCAN and (pix_valid=0 or pix_ready=1): pix_data<=rend_color, pix_addr<=address counter, pix_valid<=1.
REQ-022 Counters SHALL advance only on a load: x increments; x=H_ACTIVE-1 wraps to 0 and increments y; address counter increments by 1 (no multiplier).
REQ-023 Load of pixel (H_ACTIVE-1, V_ACTIVE-1) SHALL move SCAN to DRAIN; counters not advanced past it.
REQ-024 pix_ready=1 with no new load SHALL clear pix_valid.
REQ-025 pix_valid=1 and pix_ready=0 SHALL hold pix_addr/pix_data stable and stall counters.
REQ-026 DRAIN: when pix_valid=1 and pix_ready=1, SHALL clear pix_valid, return to IDLE, assert done for exactly the next cycle.
REQ-027 busy SHALL equal (state != IDLE).
REQ-028 Throughput SHALL be one pixel per cycle with pix_ready held high; start accepted in cycle N gives first pix_valid in cycle N+2, last pixel valid in cycle N+1+H_ACTIVE*V_ACTIVE, done in the following cycle.
REQ-029 abort=1 in SCAN or DRAIN SHALL, next cycle, force IDLE, pix_valid=0, done=0; abort takes priority over load and start; abort in IDLE SHALL have no effect.
REQ-030 A start in the same cycle as done (IDLE) SHALL be accepted.
REQ-031 rend_x/rend_y SHALL be registered counter values, stable except on load or frame start.
REQ-032 pix_addr SHALL never exceed H_ACTIVE*V_ACTIVE-1.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, pix_valid=0, busy=0, done=0, stage_out=0, rend_x=0, rend_y=0, pix_addr=0, pix_data=0, independent of clk.
REQ-034 Reset mid-frame SHALL discard the frame with no done pulse; operation resumes on start after release.

Verification
REQ-035 start with stage_sel=1, pix_ready=1 constant -> 4800 pixels, addresses 0..4799 in order, first valid 2 cycles after start, done once, 4802 cycles total.
REQ-036 pix_ready toggled pseudo-randomly -> every address delivered exactly once in order; pix_data/pix_addr unchanged while valid&!ready.
REQ-037 Renderer model returning {x[2:0],y[2:0],2'b00} -> pix_data matches address decode at (0,0), (79,0), (0,1), (79,59).
REQ-038 abort at pixel 1000 -> pix_valid low next cycle, no done, busy low; subsequent start restarts at address 0.
REQ-039 stage_sel changed and start pulsed mid-frame -> stage_out unchanged, frame unaffected.
REQ-040 rst_n low at pixel 2000 -> all outputs at reset values asynchronously; no done.
